// File: rtl/fpga_config_loader_if.sv
// Host bitstream word stream feeding the configuration loader.
interface fpga_config_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/fpga_config_loader.sv
// Serialises host words into the fabric config chain, reads back
// the returned bits, then settles and pulses the latch.
module fpga_config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 4096,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    fpga_config_loader_if.slave host,
    output logic                cfg_cen,
    output logic                cfg_shift,
    output logic                cfg_set,
    input  logic                cfg_shift_ret,
    output logic [WORD_W-1:0]   rb_data,
    output logic                rb_valid,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_SETTLE,
        S_SET,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [WORD_W-1:0] rb_sreg_q, rb_sreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;

    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              cfg_cen_q, cfg_cen_d;
    logic              cfg_shift_q, cfg_shift_d;
    logic              cfg_set_q, cfg_set_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sreg_q      <= '0;
            rb_sreg_q   <= '0;
            bit_cnt_q   <= '0;
            word_idx_q  <= '0;
            rb_data_q   <= '0;
            rb_valid_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            cfg_cen_q   <= 1'b0;
            cfg_shift_q <= 1'b0;
            cfg_set_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            rb_sreg_q   <= rb_sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            word_idx_q  <= word_idx_d;
            rb_data_q   <= rb_data_d;
            rb_valid_q  <= rb_valid_d;
            in_ready_q  <= in_ready_d;
            cfg_cen_q   <= cfg_cen_d;
            cfg_shift_q <= cfg_shift_d;
            cfg_set_q   <= cfg_set_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Outputs are registered from the next state, so they line up
    // with the state they describe rather than lagging it a cycle.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        rb_sreg_d   = rb_sreg_q;
        bit_cnt_d   = bit_cnt_q;
        word_idx_d  = word_idx_q;
        rb_data_d   = rb_data_q;
        rb_valid_d  = 1'b0;
        cfg_shift_d = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bit_cnt_d = '0;
                        state_d   = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (host.in_valid && in_ready_q) begin
                        sreg_d      = host.in_data;
                        word_idx_d  = '0;
                        rb_sreg_d   = '0;
                        cfg_shift_d = host.in_data[0];
                        state_d     = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sreg_d     = sreg_q >> 1;
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    word_idx_d = word_idx_q + IDX_W'(1);
                    rb_sreg_d  = rb_sreg_q >> 1;
                    rb_sreg_d[WORD_W-1] = cfg_shift_ret;
                    if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
                        rb_data_d  = rb_sreg_d;
                        rb_valid_d = 1'b1;
                        state_d    = S_SETTLE;
                    end else if (word_idx_d == IDX_W'(WORD_W)) begin
                        rb_data_d  = rb_sreg_d;
                        rb_valid_d = 1'b1;
                        state_d    = S_LOAD;
                    end else begin
                        cfg_shift_d = sreg_d[0];
                    end
                end
                S_SETTLE: state_d = S_SET;
                S_SET:    state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end

        in_ready_d = (state_d == S_LOAD);
        cfg_cen_d  = (state_d == S_SHIFT);
        cfg_set_d  = (state_d == S_SET);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
    end

    assign host.in_ready = in_ready_q;
    assign cfg_cen       = cfg_cen_q;
    assign cfg_shift     = cfg_shift_q;
    assign cfg_set       = cfg_set_q;
    assign rb_data       = rb_data_q;
    assign rb_valid      = rb_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Bench for fpga_config_loader: bit-stream model plus directed scenarios
// (load, readback, stall, random readback, abort, reset, start+abort).
module tb_fpga_config_loader;

    localparam int W = 8;
    localparam int L = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic cfg_shift_ret = 1'b0;
    logic cfg_cen, cfg_shift, cfg_set, rb_valid, busy, done;
    logic [W-1:0] rb_data;

    fpga_config_loader_if #(.WORD_W(W)) host();

    fpga_config_loader #(
        .WORD_W(W),
        .CHAIN_LEN(L),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .host(host),
        .cfg_cen(cfg_cen),
        .cfg_shift(cfg_shift),
        .cfg_set(cfg_set),
        .cfg_shift_ret(cfg_shift_ret),
        .rb_data(rb_data),
        .rb_valid(rb_valid),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int           exp_bits[$];
    logic [W-1:0] exp_rb[$];
    int           obs_bits[$];
    logic [W-1:0] obs_rb[$];
    int           rise[$];
    int           cen_total = 0;
    int           chunk_n = 0;
    logic [W-1:0] chunk_acc = '0;
    int           post = 0;
    int           cyc = 0;
    bit           prev_cen = 1'b0;
    bit           mdl_clear = 1'b0;
    int           ret_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ret_mode == 2) cfg_shift_ret = 1'($urandom_range(0, 1));
        else               cfg_shift_ret = ret_mode[0];
    end

    // Model: expected serial bits come from the word list; readback words
    // are rebuilt from the returned bits observed during enabled cycles.
    always @(negedge clk) begin
        int p;
        logic [W-1:0] e;
        if (mdl_clear) begin
            exp_bits.delete();
            exp_rb.delete();
            obs_bits.delete();
            obs_rb.delete();
            rise.delete();
            cen_total = 0;
            chunk_n   = 0;
            chunk_acc = '0;
            post      = 0;
            mdl_clear = 1'b0;
        end
        cyc++;
        p = post;
        chk("cen_set_excl", 32'(cfg_cen & cfg_set), 0);
        if (!cfg_cen) chk("shift_when_off", 32'(cfg_shift), 0);
        if (p != 2) chk("set_stray", 32'(cfg_set), 0);
        if (p != 3) chk("done_stray", 32'(done), 0);
        case (p)
            1: begin
                chk("settle_cen", 32'(cfg_cen), 0);
                chk("settle_busy", 32'(busy), 1);
                post = 2;
            end
            2: begin
                chk("set_pulse", 32'(cfg_set), 1);
                chk("set_busy", 32'(busy), 1);
                post = 3;
            end
            3: begin
                chk("done_pulse", 32'(done), 1);
                chk("done_busy", 32'(busy), 1);
                post = 4;
            end
            4: begin
                chk("busy_drop", 32'(busy), 0);
                post = 0;
            end
            default: ;
        endcase
        if (rb_valid) begin
            if (exp_rb.size() == 0) begin
                chk("rb_unexpected", 32'(rb_valid), 0);
            end else begin
                e = exp_rb.pop_front();
                chk("rb_data", 32'(rb_data), 32'(e));
            end
            obs_rb.push_back(rb_data);
        end
        if (cfg_cen) begin
            chk("busy_in_shift", 32'(busy), 1);
            if (exp_bits.size() == 0)
                chk("cen_unexpected", 32'(cfg_cen), 0);
            else
                chk("cfg_shift", 32'(cfg_shift), 32'(exp_bits.pop_front()));
            obs_bits.push_back(int'(cfg_shift));
            if (!prev_cen) rise.push_back(cyc);
            chunk_acc[chunk_n] = cfg_shift_ret;
            chunk_n++;
            cen_total++;
            if (chunk_n == W || cen_total == L) begin
                exp_rb.push_back(chunk_acc << (W - chunk_n));
                chunk_n   = 0;
                chunk_acc = '0;
            end
            if (cen_total == L) post = 1;
        end
        prev_cen = cfg_cen;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic new_load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2);
        logic [W-1:0] ws[3];
        int k;
        ws[0] = w0;
        ws[1] = w1;
        ws[2] = w2;
        mdl_clear = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            k = (L - i * W < W) ? L - i * W : W;
            for (int j = 0; j < k; j++) exp_bits.push_back(int'(ws[i][j]));
        end
        tick();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] d);
        bit ok = 1'b0;
        host.in_data  = d;
        host.in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (host.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 32'(ok), 1);
        @(posedge clk);
        #1;
        host.in_valid = 1'b0;
    endtask

    task automatic wait_done;
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", 32'(ok), 1);
        tick();
        tick();
    endtask

    task automatic wait_cen(input int target);
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (cen_total >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cen_wait_timeout", 32'(ok), 1);
    endtask

    function automatic logic [31:0] packed_bits();
        logic [31:0] v = '0;
        for (int i = 0; i < obs_bits.size() && i < 32; i++)
            v[i] = obs_bits[i][0];
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(host.in_ready), 0);
        chk({tag, "_cen"}, 32'(cfg_cen), 0);
        chk({tag, "_shift"}, 32'(cfg_shift), 0);
        chk({tag, "_set"}, 32'(cfg_set), 0);
        chk({tag, "_rb_valid"}, 32'(rb_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rb_data"}, 32'(rb_data), 0);
    endtask

    task automatic check_rb3(input string tag, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] c);
        chk({tag, "_rb_count"}, 32'(obs_rb.size()), 3);
        if (obs_rb.size() == 3) begin
            chk({tag, "_rb0"}, 32'(obs_rb[0]), 32'(a));
            chk({tag, "_rb1"}, 32'(obs_rb[1]), 32'(b));
            chk({tag, "_rb2"}, 32'(obs_rb[2]), 32'(c));
        end
    endtask

    initial begin
        logic [W-1:0] r0, r1, r2;
        host.in_data  = '0;
        host.in_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #1 rst = 1'b1;
        tick();

        // Full load, returned bits all ones
        ret_mode = 1;
        new_load(8'hA5, 8'h3C, 8'hFF);
        pulse_start();
        send_word(8'hA5);
        send_word(8'h3C);
        send_word(8'hFF);
        wait_done();
        chk("A_bits", packed_bits(), 32'h000F3CA5);
        chk("A_cen_count", 32'(obs_bits.size()), 20);
        check_rb3("A", 8'hFF, 8'hFF, 8'hF0);
        chk("A_rise_count", 32'(rise.size()), 3);
        if (rise.size() == 3) begin
            chk("A_word_period1", 32'(rise[1] - rise[0]), 9);
            chk("A_word_period2", 32'(rise[2] - rise[1]), 9);
        end
        chk("A_model_drained", 32'(exp_bits.size() + exp_rb.size()), 0);

        // Stall after first word, returned bits all zeros
        ret_mode = 0;
        new_load(8'hA5, 8'h3C, 8'hFF);
        pulse_start();
        send_word(8'hA5);
        begin
            bit ok = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (host.in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("B_reload_timeout", 32'(ok), 1);
        end
        for (int i = 0; i < 5; i++) begin
            chk("B_stall_ready", 32'(host.in_ready), 1);
            chk("B_stall_cen", 32'(cfg_cen), 0);
            if (i < 4) @(negedge clk);
        end
        tick();
        send_word(8'h3C);
        send_word(8'hFF);
        wait_done();
        chk("B_bits", packed_bits(), 32'h000F3CA5);
        chk("B_cen_count", 32'(obs_bits.size()), 20);
        check_rb3("B", 8'h00, 8'h00, 8'h00);

        // Random data and returned bits, start held high meanwhile
        ret_mode = 2;
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        new_load(r0, r1, r2);
        start = 1'b1;
        tick();
        send_word(r0);
        send_word(r1);
        start = 1'b0;
        send_word(r2);
        wait_done();
        chk("C_cen_count", 32'(obs_bits.size()), 20);
        chk("C_rb_count", 32'(obs_rb.size()), 3);
        chk("C_model_drained", 32'(exp_bits.size() + exp_rb.size()), 0);

        // Abort five bits into the second word, then restart
        ret_mode = 1;
        new_load(8'hA5, 8'h3C, 8'hFF);
        pulse_start();
        send_word(8'hA5);
        send_word(8'h3C);
        wait_cen(13);
        abort = 1'b1;
        @(negedge clk);
        chk("D_abort_cen", 32'(cfg_cen), 0);
        chk("D_abort_busy", 32'(busy), 0);
        chk("D_abort_rbv", 32'(rb_valid), 0);
        #1 abort = 1'b0;
        mdl_clear = 1'b1;
        repeat (8) tick();
        chk("D_idle_ready", 32'(host.in_ready), 0);
        new_load(8'hA5, 8'h3C, 8'hFF);
        pulse_start();
        send_word(8'hA5);
        send_word(8'h3C);
        send_word(8'hFF);
        wait_done();
        chk("D_restart_bits", packed_bits(), 32'h000F3CA5);
        chk("D_restart_cen_count", 32'(obs_bits.size()), 20);
        check_rb3("D", 8'hFF, 8'hFF, 8'hF0);

        // Reset in the middle of shifting
        new_load(8'hA5, 8'h3C, 8'hFF);
        pulse_start();
        send_word(8'hA5);
        wait_cen(3);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("E_rst_mid");
        #1 rst = 1'b1;
        mdl_clear = 1'b1;
        repeat (4) tick();

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("F_idle_busy", 32'(busy), 0);
            chk("F_idle_ready", 32'(host.in_ready), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
